// File: rtl/periph_access_arbiter_pkg.sv
// periph_access_arbiter_pkg
//   Shared types and helpers for the peripheral access arbiter.
//   - arbState_e : controller FSM state encoding (3-bit).
//   - idxWidth   : width of a port index for a given port count (min 1).
package periph_access_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_R_BUSY = 3'd2,
        S_W_BUSY = 3'd3,
        S_RESP   = 3'd4
    } arbState_e;

    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_access_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector: returns the first requesting port at
//   or after the pointer, wrapping at NUM_PORTS.
// Ports
//   req      in   NUM_PORTS  request vector
//   ptr      in   IDX_W      round-robin start position
//   grantOh  out  NUM_PORTS  one-hot grant (all zero when no request)
//   grantIdx out  IDX_W      index of the granted port
//   anyReq   out  1          at least one request present
module rr_pick #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grantOh,
    output logic [IDX_W-1:0]     grantIdx,
    output logic                 anyReq
);

    logic        found;
    int unsigned pos;

    assign anyReq = |req;

    always_comb begin
        grantOh  = '0;
        grantIdx = '0;
        found    = 1'b0;
        pos      = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NUM_PORTS) begin
                pos = pos - NUM_PORTS;
            end
            if (!found && req[pos]) begin
                grantOh[pos] = 1'b1;
                grantIdx     = pos[IDX_W-1:0];
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_access_arbiter.sv
// periph_access_arbiter
//   Round-robin arbiter placing NUM_PORTS requesters onto one AXI-lite master
//   bridge. The winner's address/write data are latched, a one-cycle start
//   pulse is issued, and the requester is stalled until its own response.
//   Optional bus timeout is built when the macro PERIPH_TIMEOUT_EN is defined;
//   otherwise the controller waits indefinitely and Error is tied to 0.
// Ports
//   Clk, nRst              clock (rising edge), async active-low reset
//   Req, RW, Addr, WData   per-port request, direction (1=write), flattened addr/data
//   Stall                  per-port stall (Req & ~RespValid)
//   RespValid, Error       one-cycle per-port response pulse, timeout flag
//   RData                  read data, held until the next read completes
//   StartAXIRead/Write     one-cycle bridge start pulses
//   AXIAddr, AXIWData      latched address/write data for the bridge
//   AXIRData               bridge read data, valid with ReadCompleted
//   ReadCompleted          bridge read done pulse
//   WriteCompleted         bridge write done pulse
module periph_access_arbiter
    import periph_access_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        Clk,
    input  logic                        nRst,
    input  logic [NUM_PORTS-1:0]        Req,
    input  logic [NUM_PORTS-1:0]        RW,
    input  logic [NUM_PORTS*ADDR_W-1:0] Addr,
    input  logic [NUM_PORTS*DATA_W-1:0] WData,
    output logic [NUM_PORTS-1:0]        Stall,
    output logic [NUM_PORTS-1:0]        RespValid,
    output logic [NUM_PORTS-1:0]        Error,
    output logic [DATA_W-1:0]           RData,
    output logic                        StartAXIRead,
    output logic                        StartAXIWrite,
    output logic [ADDR_W-1:0]           AXIAddr,
    output logic [DATA_W-1:0]           AXIWData,
    input  logic [DATA_W-1:0]           AXIRData,
    input  logic                        ReadCompleted,
    input  logic                        WriteCompleted
);

    localparam int unsigned IDX_W = idxWidth(NUM_PORTS);

    if (NUM_PORTS < 1 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : gParamCheck
        $error("periph_access_arbiter: parameter out of range");
    end

    arbState_e          state, stateNext;
    logic [IDX_W-1:0]     rrPtr, grantIdx, pickIdx, ptrNext;
    logic [NUM_PORTS-1:0] pickOh;
    logic                 anyReq, rwQ, respFire, timeoutHit;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) uPick (
        .req      (Req),
        .ptr      (rrPtr),
        .grantOh  (pickOh),
        .grantIdx (pickIdx),
        .anyReq   (anyReq)
    );

    assign ptrNext = (grantIdx == IDX_W'(NUM_PORTS - 1)) ? '0 : grantIdx + 1'b1;
    assign Stall   = Req & ~RespValid;

    always_comb begin
        stateNext     = state;
        StartAXIRead  = 1'b0;
        StartAXIWrite = 1'b0;
        respFire      = 1'b0;
        case (state)
            S_IDLE:   if (anyReq) stateNext = S_ISSUE;
            S_ISSUE: begin
                StartAXIRead  = ~rwQ;
                StartAXIWrite = rwQ;
                stateNext     = rwQ ? S_W_BUSY : S_R_BUSY;
            end
            S_R_BUSY: if (ReadCompleted || timeoutHit) stateNext = S_RESP;
            S_W_BUSY: if (WriteCompleted || timeoutHit) stateNext = S_RESP;
            S_RESP: begin
                respFire  = 1'b1;
                stateNext = S_IDLE;
            end
            default:  stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        RespValid = '0;
        if (respFire) begin
            RespValid[grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state    <= S_IDLE;
            rrPtr    <= '0;
            grantIdx <= '0;
            rwQ      <= 1'b0;
            AXIAddr  <= '0;
            AXIWData <= '0;
            RData    <= '0;
        end else begin
            state <= stateNext;
            case (state)
                S_IDLE: begin
                    if (anyReq) begin
                        grantIdx <= pickIdx;
                        rwQ      <= |(RW & pickOh);
                        AXIAddr  <= Addr[pickIdx*ADDR_W +: ADDR_W];
                        AXIWData <= WData[pickIdx*DATA_W +: DATA_W];
                    end
                end
                S_ISSUE:  rrPtr <= ptrNext;
                // A completion in the timeout cycle takes priority over the error path.
                S_R_BUSY: begin
                    if (ReadCompleted) begin
                        RData <= AXIRData;
                    end else if (timeoutHit) begin
                        RData <= '0;
                    end
                end
                S_W_BUSY: begin
                    if (!WriteCompleted && timeoutHit) begin
                        RData <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PERIPH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmoCnt;
    logic             errQ;

    // Counter is 0 in the first BUSY cycle, so the last allowed cycle holds TIMEOUT_CYCLES-1.
    assign timeoutHit = ((state == S_R_BUSY) || (state == S_W_BUSY)) &&
                        (tmoCnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign Error      = errQ ? RespValid : '0;

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            tmoCnt <= '0;
            errQ   <= 1'b0;
        end else begin
            case (state)
                S_ISSUE: begin
                    tmoCnt <= '0;
                    errQ   <= 1'b0;
                end
                S_R_BUSY: begin
                    tmoCnt <= tmoCnt + 1'b1;
                    if (timeoutHit && !ReadCompleted) errQ <= 1'b1;
                end
                S_W_BUSY: begin
                    tmoCnt <= tmoCnt + 1'b1;
                    if (timeoutHit && !WriteCompleted) errQ <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign Error      = '0;
`endif

endmodule

// File: tb/tb_periph_access_arbiter.sv
// tb_periph_access_arbiter
//   Directed self-checking bench for periph_access_arbiter (NUM_PORTS=2).
//   Timeout scenario is built only when PERIPH_TIMEOUT_EN is defined.
module tb_periph_access_arbiter;

    logic        Clk = 1'b0;
    logic        nRst;
    logic [1:0]  Req, RW, Stall, RespValid, Error;
    logic [63:0] Addr, WData;
    logic [31:0] RData, AXIAddr, AXIWData, AXIRData;
    logic        StartAXIRead, StartAXIWrite, ReadCompleted, WriteCompleted;

    logic [31:0] addrOf [2];
    logic [31:0] wdOf   [2];

    int nChecks = 0;
    int nPass   = 0;

    always #5 Clk = ~Clk;

    periph_access_arbiter #(
        .NUM_PORTS      (2),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .Clk            (Clk),
        .nRst           (nRst),
        .Req            (Req),
        .RW             (RW),
        .Addr           (Addr),
        .WData          (WData),
        .Stall          (Stall),
        .RespValid      (RespValid),
        .Error          (Error),
        .RData          (RData),
        .StartAXIRead   (StartAXIRead),
        .StartAXIWrite  (StartAXIWrite),
        .AXIAddr        (AXIAddr),
        .AXIWData       (AXIWData),
        .AXIRData       (AXIRData),
        .ReadCompleted  (ReadCompleted),
        .WriteCompleted (WriteCompleted)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            nPass++;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Waits (bounded) for the start pulse of the next access, checks it belongs
    // to 'port', completes it one BUSY cycle later and checks the response.
    task automatic serve(input int port, input bit isWrite, input logic [31:0] rd);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 6) begin
            tick();
            n++;
            if (StartAXIRead || StartAXIWrite) seen = 1'b1;
        end
        check("start_seen", 64'(seen), 64'd1);
        check("start_kind", {StartAXIWrite, StartAXIRead}, isWrite ? 2'b10 : 2'b01);
        check("axi_addr", AXIAddr, addrOf[port]);
        if (isWrite) check("axi_wdata", AXIWData, wdOf[port]);
        tick();
        check("start_once", {StartAXIWrite, StartAXIRead}, 2'b00);
        if (isWrite) WriteCompleted = 1'b1;
        else begin
            ReadCompleted = 1'b1;
            AXIRData      = rd;
        end
        tick();
        ReadCompleted  = 1'b0;
        WriteCompleted = 1'b0;
        check("resp_port", RespValid, 2'b01 << port);
        check("resp_err", Error, 2'b00);
        if (!isWrite) check("resp_rdata", RData, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        addrOf[0] = 32'h4000_0010; addrOf[1] = 32'h5000_0020;
        wdOf[0]   = 32'h1111_AAAA; wdOf[1]   = 32'h2222_BBBB;
        Addr  = {addrOf[1], addrOf[0]};
        WData = {wdOf[1], wdOf[0]};
        nRst = 1'b0; Req = 2'b00; RW = 2'b00;
        AXIRData = '0; ReadCompleted = 1'b0; WriteCompleted = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_resp", RespValid, 2'b00);
        check("rst_start", {StartAXIWrite, StartAXIRead}, 2'b00);
        check("rst_rdata", RData, 32'h0);
        check("rst_axiaddr", AXIAddr, 32'h0);
        nRst = 1'b1;

        // 1: single read on port 0, completion 3 cycles after the start pulse
        Req = 2'b01; RW = 2'b00;                                   // cycle 0
        #1;
        check("t1_stall_c0", Stall, 2'b01);
        tick();                                                    // cycle 1
        check("t1_start_c1", {StartAXIWrite, StartAXIRead}, 2'b01);
        check("t1_addr", AXIAddr, 32'h4000_0010);
        tick(); check("t1_stall_c2", Stall, 2'b01);
        check("t1_nostart_c2", {StartAXIWrite, StartAXIRead}, 2'b00);
        tick(); check("t1_stall_c3", Stall, 2'b01);
        tick();                                                    // cycle 4
        check("t1_stall_c4", Stall, 2'b01);
        check("t1_noresp_c4", RespValid, 2'b00);
        ReadCompleted = 1'b1; AXIRData = 32'hDEAD_BEEF;
        tick();                                                    // cycle 5
        ReadCompleted = 1'b0;
        check("t1_resp_c5", RespValid, 2'b01);
        check("t1_err_c5", Error, 2'b00);
        check("t1_rdata", RData, 32'hDEAD_BEEF);
        check("t1_stall_c5", Stall, 2'b00);
        Req = 2'b00;
        tick();
        check("t1_resp_c6", RespValid, 2'b00);

        // 2: both ports writing; pointer is 1 after the port-0 grant above
        Req = 2'b11; RW = 2'b11;
        serve(1, 1'b1, '0);
        serve(0, 1'b1, '0);
        serve(1, 1'b1, '0);
        serve(0, 1'b1, '0);
        Req = 2'b00;
        check("t2_rdata_kept", RData, 32'hDEAD_BEEF);

        // 3: spurious ReadCompleted in IDLE and during W_BUSY
        tick();
        ReadCompleted = 1'b1; AXIRData = 32'h0BAD_0BAD;
        tick();
        ReadCompleted = 1'b0;
        check("t3_idle_resp", RespValid, 2'b00);
        check("t3_idle_start", {StartAXIWrite, StartAXIRead}, 2'b00);
        check("t3_idle_rdata", RData, 32'hDEAD_BEEF);
        Req = 2'b01; RW = 2'b01;
        tick();
        check("t3_start", {StartAXIWrite, StartAXIRead}, 2'b10);
        tick();
        ReadCompleted = 1'b1;
        tick();
        ReadCompleted = 1'b0;
        check("t3_busy_resp", RespValid, 2'b00);
        check("t3_busy_stall", Stall, 2'b01);
        WriteCompleted = 1'b1;
        tick();
        WriteCompleted = 1'b0;
        check("t3_resp", RespValid, 2'b01);
        check("t3_rdata_kept", RData, 32'hDEAD_BEEF);
        Req = 2'b00;

        // 4: port 0 drops Req during its read; port 1 requests meanwhile
        tick();
        Req = 2'b01; RW = 2'b00;
        tick();
        check("t4_start", {StartAXIWrite, StartAXIRead}, 2'b01);
        check("t4_addr", AXIAddr, addrOf[0]);
        tick();
        Req = 2'b10; RW = 2'b10;
        #1;
        check("t4_stall", Stall, 2'b10);
        tick();
        ReadCompleted = 1'b1; AXIRData = 32'h1234_5678;
        tick();
        ReadCompleted = 1'b0;
        check("t4_resp", RespValid, 2'b01);
        check("t4_rdata", RData, 32'h1234_5678);
        check("t4_stall_resp", Stall, 2'b10);
        serve(1, 1'b1, '0);
        Req = 2'b00;

`ifdef PERIPH_TIMEOUT_EN
        // 5: read with no completion times out after 4 BUSY cycles
        tick();
        Req = 2'b01; RW = 2'b00;
        tick();
        check("t5_start", {StartAXIWrite, StartAXIRead}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_wait", RespValid, 2'b00);
        end
        tick();
        check("t5_resp", RespValid, 2'b01);
        check("t5_err", Error, 2'b01);
        check("t5_rdata", RData, 32'h0);
        Req = 2'b00;
        tick();
        ReadCompleted = 1'b1; AXIRData = 32'hCAFE_F00D;
        tick();
        ReadCompleted = 1'b0;
        check("t5_late_resp", RespValid, 2'b00);
        check("t5_late_rdata", RData, 32'h0);
`endif

        // 6: reset while in W_BUSY after a port-0 grant (pointer would be 1)
        tick();
        Req = 2'b01; RW = 2'b01;
        tick();
        check("t6_start", {StartAXIWrite, StartAXIRead}, 2'b10);
        tick();
        #2;
        nRst = 1'b0; Req = 2'b00;
        #1;
        check("t6_rst_start", {StartAXIWrite, StartAXIRead}, 2'b00);
        check("t6_rst_resp", RespValid, 2'b00);
        check("t6_rst_rdata", RData, 32'h0);
        check("t6_rst_addr", AXIAddr, 32'h0);
        check("t6_rst_wdata", AXIWData, 32'h0);
        check("t6_rst_stall", Stall, 2'b00);
        tick();
        nRst = 1'b1;
        tick();
        Req = 2'b11; RW = 2'b00;
        serve(0, 1'b0, 32'h5A5A_0001);
        Req = 2'b00;
        tick();
        Req = 2'b10; RW = 2'b00;
        serve(1, 1'b0, 32'hA5A5_0002);
        Req = 2'b00;
        tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
